// File: rtl/axis_controller_mux_pkg.sv
// Shared definitions for the axis_controller_mux command generator.
//   - FSM state encodings (IDLE=0, SEND=1)
//   - width helpers: slot word width, command word width, channel index width
package axis_controller_mux_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  // One slot carries {addr, data} for a single channel.
  function automatic int calc_slot_w(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

  // Command word: constant header above CHANNELS slots.
  function automatic int calc_out_w(input int header_w, input int channels,
                                    input int addr_w, input int data_w);
    return header_w + channels * (addr_w + data_w);
  endfunction

  // Width of the channel index; a single-channel build still needs one bit.
  function automatic int calc_idx_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/axis_controller_slot.sv
// Combinational slot builder: selects channel index_i from the multi-channel
// sample and pairs it with that channel's register address.
// Ports:
//   index_i   channel index
//   sample_i  multi-channel sample, ch i at bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
//   slot_o    {addr(index_i), data(index_i)}
module axis_controller_slot
  import axis_controller_mux_pkg::*;
#(
  parameter int                    CHANNELS   = 2,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE  = 8'h11,
  parameter logic [ADDR_WIDTH-1:0] ADDR_STEP  = 8'h03,
  parameter int                    IDX_W      = calc_idx_w(CHANNELS)
) (
  input  logic [IDX_W-1:0]                 index_i,
  input  logic [CHANNELS*DATA_WIDTH-1:0]   sample_i,
  output logic [ADDR_WIDTH+DATA_WIDTH-1:0] slot_o
);

  logic [ADDR_WIDTH-1:0] idx_ext_s;
  logic [ADDR_WIDTH-1:0] addr_s;
  logic [DATA_WIDTH-1:0] data_s;

  // Address arithmetic wraps modulo 2^ADDR_WIDTH, so truncating the index first is harmless.
  assign idx_ext_s = ADDR_WIDTH'(index_i);
  assign addr_s    = ADDR_BASE + idx_ext_s * ADDR_STEP;

  // Channel data select; an out-of-range index yields zero data.
  always_comb begin
    data_s = {DATA_WIDTH{1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      if (index_i == IDX_W'(c)) begin
        data_s = sample_i[c*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        data_s = data_s;
      end
    end
  end

  assign slot_o = {addr_s, data_s};

endmodule

// File: rtl/axis_controller_mux.sv
// Rate-limited AXI-Stream register-write command generator.
// Accepts one multi-channel sample at most every cfg_period+1 cycles and emits
// {HEADER, slots} command words, either all channels in one beat (packed) or
// one channel per beat (sequential), with downstream backpressure and tlast.
// Ports:
//   aclk, areset      clock, synchronous active-high reset
//   cfg_period        minimum acceptance spacing minus one
//   cfg_mode          0 = packed, 1 = sequential
//   s_axis_*          sample input stream
//   m_axis_*          command output stream (registered)
//   sts_busy          not IDLE or rate counter still running
module axis_controller_mux
  import axis_controller_mux_pkg::*;
#(
  parameter int                      CHANNELS     = 2,
  parameter int                      DATA_WIDTH   = 16,
  parameter int                      ADDR_WIDTH   = 8,
  parameter logic [ADDR_WIDTH-1:0]   ADDR_BASE    = 8'h11,
  parameter logic [ADDR_WIDTH-1:0]   ADDR_STEP    = 8'h03,
  parameter int                      HEADER_WIDTH = 48,
  parameter logic [HEADER_WIDTH-1:0] HEADER       = 48'h000000250000,
  parameter int                      CNTR_WIDTH   = 32
) (
  input  logic                                                          aclk,
  input  logic                                                          areset,
  input  logic [CNTR_WIDTH-1:0]                                         cfg_period,
  input  logic                                                          cfg_mode,
  input  logic [CHANNELS*DATA_WIDTH-1:0]                                s_axis_tdata,
  input  logic                                                          s_axis_tvalid,
  output logic                                                          s_axis_tready,
  output logic [HEADER_WIDTH+CHANNELS*(ADDR_WIDTH+DATA_WIDTH)-1:0]      m_axis_tdata,
  output logic                                                          m_axis_tvalid,
  input  logic                                                          m_axis_tready,
  output logic                                                          m_axis_tlast,
  output logic                                                          sts_busy
);

  localparam int SLOT_W = calc_slot_w(ADDR_WIDTH, DATA_WIDTH);
  localparam int OUT_W  = calc_out_w(HEADER_WIDTH, CHANNELS, ADDR_WIDTH, DATA_WIDTH);
  localparam int IDX_W  = calc_idx_w(CHANNELS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

  // Registered state
  logic [0:0]                   state_q,   state_d;
  logic [CNTR_WIDTH-1:0]        counter_q, counter_d;
  logic [IDX_W-1:0]             index_q,   index_d;
  logic [CHANNELS*DATA_WIDTH-1:0] sample_q, sample_d;
  logic                         mode_q,    mode_d;
  logic [OUT_W-1:0]             tdata_q,   tdata_d;
  logic                         tvalid_q,  tvalid_d;
  logic                         tlast_q,   tlast_d;

  // Next-beat construction
  logic                           accept_s;
  logic                           next_mode_s;
  logic [CHANNELS*DATA_WIDTH-1:0] src_sample_s;
  logic [IDX_W-1:0]               seq_index_s;
  logic                           seq_last_s;
  logic [SLOT_W-1:0]              seq_slot_s;
  logic [CHANNELS*SLOT_W-1:0]     packed_slots_s;
  logic [OUT_W-1:0]               packed_beat_s;
  logic [OUT_W-1:0]               seq_beat_s;
  logic [OUT_W-1:0]               next_beat_s;

  assign s_axis_tready = ~areset & (state_q == ST_IDLE) & (counter_q == {CNTR_WIDTH{1'b0}});
  assign accept_s      = s_axis_tvalid & s_axis_tready;

  // The output is registered, so the next beat is built from the incoming
  // sample on acceptance and from the latched copy while sending.
  assign src_sample_s = accept_s ? s_axis_tdata : sample_q;
  assign next_mode_s  = accept_s ? cfg_mode : mode_q;
  assign seq_index_s  = accept_s ? {IDX_W{1'b0}} : (index_q + IDX_W'(1));
  assign seq_last_s   = (seq_index_s == LAST_IDX);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_packed_slot
    axis_controller_slot #(
      .CHANNELS   (CHANNELS),
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ADDR_BASE  (ADDR_BASE),
      .ADDR_STEP  (ADDR_STEP),
      .IDX_W      (IDX_W)
    ) u_slot (
      .index_i  (IDX_W'(c)),
      .sample_i (src_sample_s),
      .slot_o   (packed_slots_s[c*SLOT_W +: SLOT_W])
    );
  end

  axis_controller_slot #(
    .CHANNELS   (CHANNELS),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ADDR_BASE  (ADDR_BASE),
    .ADDR_STEP  (ADDR_STEP),
    .IDX_W      (IDX_W)
  ) u_seq_slot (
    .index_i  (seq_index_s),
    .sample_i (src_sample_s),
    .slot_o   (seq_slot_s)
  );

  // Assemble packed and sequential beats; sequential keeps only slot 0 populated.
  always_comb begin
    packed_beat_s = {HEADER, packed_slots_s};
    seq_beat_s    = {OUT_W{1'b0}};
    seq_beat_s[SLOT_W-1:0] = seq_slot_s;
    seq_beat_s[OUT_W-1 -: HEADER_WIDTH] = HEADER;
    if (next_mode_s) begin
      next_beat_s = seq_beat_s;
    end else begin
      next_beat_s = packed_beat_s;
    end
  end

  // Rate counter: reloads on acceptance, otherwise counts down to zero and holds.
  always_comb begin
    if (accept_s) begin
      counter_d = cfg_period;
    end else if (counter_q != {CNTR_WIDTH{1'b0}}) begin
      counter_d = counter_q - CNTR_WIDTH'(1);
    end else begin
      counter_d = counter_q;
    end
  end

  // FSM next-state and output-register next values.
  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    sample_d = sample_q;
    mode_d   = mode_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d  = ST_SEND;
          sample_d = s_axis_tdata;
          mode_d   = cfg_mode;
          index_d  = {IDX_W{1'b0}};
          tdata_d  = next_beat_s;
          tvalid_d = 1'b1;
          tlast_d  = cfg_mode ? seq_last_s : 1'b1;
        end else begin
          tvalid_d = 1'b0;
        end
      end
      ST_SEND: begin
        if (m_axis_tready) begin
          if (tlast_q) begin
            state_d  = ST_IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
          end else begin
            // Only sequential mode reaches here: present the next channel without a gap.
            index_d = seq_index_s;
            tdata_d = next_beat_s;
            tlast_d = seq_last_s;
          end
        end else begin
          tvalid_d = tvalid_q;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset; reset drops any beat in flight.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= ST_IDLE;
      counter_q <= {CNTR_WIDTH{1'b0}};
      index_q   <= {IDX_W{1'b0}};
      sample_q  <= {(CHANNELS*DATA_WIDTH){1'b0}};
      mode_q    <= 1'b0;
      tdata_q   <= {OUT_W{1'b0}};
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      index_q   <= index_d;
      sample_q  <= sample_d;
      mode_q    <= mode_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign sts_busy      = (state_q != ST_IDLE) | (counter_q != {CNTR_WIDTH{1'b0}});

endmodule

// File: tb/tb_axis_controller_mux.sv
// Self-checking bench for axis_controller_mux (default parameters).
// Expected beats are pushed to a scoreboard when a sample is accepted and
// compared when the DUT completes an output handshake.
module tb_axis_controller_mux;

  localparam logic [47:0] HDR = 48'h000000250000;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [31:0] cfg_period = 32'd0;
  logic        cfg_mode = 1'b0;
  logic [31:0] s_tdata = 32'd0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [95:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tlast;
  logic        sts_busy;

  axis_controller_mux dut (
    .aclk          (aclk),
    .areset        (areset),
    .cfg_period    (cfg_period),
    .cfg_mode      (cfg_mode),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .sts_busy      (sts_busy)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [95:0] data;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  logic [95:0] beat_log[$];
  logic        last_log[$];
  int          hs_cyc[$];
  int          acc_cyc[$];
  int          acc_count = 0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic        busy_watch = 1'b0;
  int          busy_base = 0;
  int          busy_low = 0;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] model_slot(input int ch, input logic [31:0] smp);
    logic [7:0] a;
    a = 8'h11 + 8'(ch * 3);
    return {a, smp[ch*16 +: 16]};
  endfunction

  always @(posedge aclk) cyc <= cyc + 1;

  // Monitor: input handshake pushes expectations, output handshake pops and compares.
  always @(negedge aclk) begin
    beat_t b;
    beat_t e;
    if (!areset) begin
      if (s_tvalid && s_tready) begin
        if (!cfg_mode) begin
          b.data = {HDR, model_slot(1, s_tdata), model_slot(0, s_tdata)};
          b.last = 1'b1;
          exp_q.push_back(b);
        end else begin
          for (int i = 0; i < 2; i++) begin
            b.data = {HDR, 24'h000000, model_slot(i, s_tdata)};
            b.last = (i == 1);
            exp_q.push_back(b);
          end
        end
        acc_count++;
        acc_cyc.push_back(cyc);
      end else if (busy_watch && acc_count >= busy_base + 1 && acc_count < busy_base + 3 && !sts_busy) begin
        busy_low++;
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_beat", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check_val("beat_data", m_tdata, e.data);
          check_val("beat_last", m_tlast, e.last);
        end
        beat_log.push_back(m_tdata);
        last_log.push_back(m_tlast);
        hs_cyc.push_back(cyc);
      end
    end
  end

  task automatic send_sample(input logic [31:0] data, input logic mode);
    logic ok;
    @(posedge aclk); #1;
    s_tdata  = data;
    cfg_mode = mode;
    s_tvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      if (s_tready) begin
        ok = 1'b1;
        break;
      end
    end
    check_val("accept_timeout", ok, 1'b1);
    @(posedge aclk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge aclk); #1;
      if (exp_q.size() == 0 && !m_tvalid && !sts_busy) begin
        ok = 1'b1;
        break;
      end
    end
    check_val("drain_timeout", ok, 1'b1);
  endtask

  initial begin
    int base;
    logic [31:0] d;
    logic [95:0] exp_beat;

    // Reset state
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    check_val("rst_tvalid", m_tvalid, 1'b0);
    check_val("rst_tdata", m_tdata, 96'h0);
    check_val("rst_tlast", m_tlast, 1'b0);
    check_val("rst_s_tready", s_tready, 1'b0);
    check_val("rst_busy", sts_busy, 1'b0);
    areset = 1'b0;
    #1;
    check_val("idle_s_tready", s_tready, 1'b1);

    // Packed, one beat
    base = beat_log.size();
    send_sample(32'hABCD1234, 1'b0);
    drain();
    check_val("packed_beats", beat_log.size() - base, 1);
    check_val("packed_literal", beat_log[base], 96'h000000250000_14ABCD_111234);
    check_val("packed_last", last_log[base], 1'b1);

    // Sequential, two back-to-back beats
    base = beat_log.size();
    send_sample(32'hABCD1234, 1'b1);
    drain();
    check_val("seq_beats", beat_log.size() - base, 2);
    check_val("seq_beat0", beat_log[base], 96'h000000250000_000000_111234);
    check_val("seq_last0", last_log[base], 1'b0);
    check_val("seq_beat1", beat_log[base+1], 96'h000000250000_000000_14ABCD);
    check_val("seq_last1", last_log[base+1], 1'b1);
    check_val("seq_no_gap", hs_cyc[base+1] - hs_cyc[base], 1);

    // Rate limit: cfg_period=9, tvalid held high
    @(posedge aclk); #1;
    cfg_period = 32'd9;
    cfg_mode   = 1'b0;
    s_tdata    = $urandom;
    busy_base  = acc_count;
    busy_low   = 0;
    busy_watch = 1'b1;
    s_tvalid   = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(posedge aclk);
      if (acc_count >= busy_base + 3) break;
    end
    #1;
    s_tvalid   = 1'b0;
    busy_watch = 1'b0;
    cfg_period = 32'd0;
    check_val("rate_acc_count", acc_count - busy_base, 3);
    if (acc_count - busy_base >= 3) begin
      check_val("rate_gap1", acc_cyc[busy_base+1] - acc_cyc[busy_base], 10);
      check_val("rate_gap2", acc_cyc[busy_base+2] - acc_cyc[busy_base+1], 10);
    end
    check_val("rate_busy_between", busy_low, 0);
    drain();

    // Packed with 5-cycle backpressure
    base = beat_log.size();
    d = $urandom;
    m_tready = 1'b0;
    send_sample(d, 1'b0);
    s_tdata  = $urandom;
    s_tvalid = 1'b1;
    exp_beat = {HDR, model_slot(1, d), model_slot(0, d)};
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check_val("stall_tvalid", m_tvalid, 1'b1);
      check_val("stall_tdata", m_tdata, exp_beat);
      check_val("stall_s_tready", s_tready, 1'b0);
    end
    @(posedge aclk); #1;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    drain();
    check_val("stall_single_hs", beat_log.size() - base, 1);

    // cfg_mode toggled during SEND: current sample stays packed, next is sequential
    base = beat_log.size();
    m_tready = 1'b0;
    send_sample($urandom, 1'b0);
    cfg_mode = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    m_tready = 1'b1;
    send_sample($urandom, 1'b1);
    drain();
    check_val("toggle_beats", beat_log.size() - base, 3);

    // Reset during sequential beat1
    m_tready = 1'b1;
    send_sample($urandom, 1'b1);
    @(posedge aclk); #1;
    areset   = 1'b1;
    m_tready = 1'b0;
    check_val("rst_mid_pending", exp_q.size(), 1);
    @(posedge aclk); #1;
    check_val("rst_mid_tvalid", m_tvalid, 1'b0);
    check_val("rst_mid_tdata", m_tdata, 96'h0);
    check_val("rst_mid_tlast", m_tlast, 1'b0);
    check_val("rst_mid_busy", sts_busy, 1'b0);
    exp_q.delete();
    areset   = 1'b0;
    m_tready = 1'b1;
    base = beat_log.size();
    d = 32'h5A5A0F0F;
    send_sample(d, 1'b1);
    drain();
    check_val("post_rst_beats", beat_log.size() - base, 2);
    check_val("post_rst_beat0", beat_log[base], {HDR, 24'h000000, 8'h11, d[15:0]});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
